// File: rtl/morse_decoder.sv
// Morse receive path: measures mark/space run lengths on morse_in, assembles
// up to 4 dot/dash elements and emits the letter index on a character gap.
module morse_decoder #(
  parameter int DOT_MIN   = 20,
  parameter int DASH_MIN  = 150,
  parameter int CHAR_GAP  = 300,
  parameter int CNT_WIDTH = $clog2(CHAR_GAP + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       morse_in,
  output logic       char_valid,
  output logic [4:0] char_sel,
  output logic [2:0] char_len,
  output logic [3:0] char_code,
  output logic       char_err,
  output logic [1:0] state_debug
);

  typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] DOT_MIN_C  = CNT_WIDTH'(DOT_MIN);
  localparam logic [CNT_WIDTH-1:0] DASH_MIN_C = CNT_WIDTH'(DASH_MIN);
  // The first space sample is counted on the MARK exit edge, so the gap
  // completes on the edge where the counter already holds CHAR_GAP-1.
  localparam logic [CNT_WIDTH-1:0] GAP_LAST_C = CNT_WIDTH'(CHAR_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]           count, count_n;
  logic [3:0]           code, code_n;
  logic                 ovf, ovf_n;
  logic                 emit;
  logic [4:0]           dec_sel;
  logic [2:0]           emit_len;

  function automatic logic [4:0] decode(input logic [2:0] len, input logic [3:0] c);
    logic [4:0] s;
    s = 5'b11111;
    case ({len, c})
      {3'd1, 4'b0000}: s = 5'd4;
      {3'd1, 4'b0001}: s = 5'd19;
      {3'd2, 4'b0000}: s = 5'd8;
      {3'd2, 4'b0010}: s = 5'd0;
      {3'd2, 4'b0001}: s = 5'd13;
      {3'd2, 4'b0011}: s = 5'd12;
      {3'd3, 4'b0000}: s = 5'd18;
      {3'd3, 4'b0001}: s = 5'd3;
      {3'd3, 4'b0010}: s = 5'd17;
      {3'd3, 4'b0011}: s = 5'd6;
      {3'd3, 4'b0100}: s = 5'd20;
      {3'd3, 4'b0101}: s = 5'd10;
      {3'd3, 4'b0110}: s = 5'd22;
      {3'd3, 4'b0111}: s = 5'd14;
      {3'd4, 4'b0000}: s = 5'd7;
      {3'd4, 4'b0001}: s = 5'd1;
      {3'd4, 4'b0010}: s = 5'd11;
      {3'd4, 4'b0011}: s = 5'd25;
      {3'd4, 4'b0100}: s = 5'd5;
      {3'd4, 4'b0101}: s = 5'd2;
      {3'd4, 4'b0110}: s = 5'd15;
      {3'd4, 4'b1000}: s = 5'd21;
      {3'd4, 4'b1001}: s = 5'd23;
      {3'd4, 4'b1011}: s = 5'd16;
      {3'd4, 4'b1101}: s = 5'd24;
      {3'd4, 4'b1110}: s = 5'd9;
      default:         s = 5'b11111;
    endcase
    return s;
  endfunction

  assign cnt_inc  = (&cnt) ? cnt : cnt + ONE_C;
  assign emit_len = ovf ? 3'd5 : count;
  assign dec_sel  = decode(emit_len, code);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    count_n = count;
    code_n  = code;
    ovf_n   = ovf;
    emit    = 1'b0;
    case (state)
      IDLE: if (morse_in) begin
        state_n = MARK;
        cnt_n   = ONE_C;
      end
      MARK: if (morse_in) begin
        cnt_n = cnt_inc;
      end else begin
        cnt_n = ONE_C;
        if (cnt < DOT_MIN_C) begin
          state_n = (count != 3'd0) ? SPACE : IDLE;
        end else begin
          state_n = SPACE;
          if (count == 3'd4) begin
            ovf_n = 1'b1;
          end else begin
            code_n[count[1:0]] = (cnt >= DASH_MIN_C);
            count_n            = count + 3'd1;
          end
        end
      end
      SPACE: if (morse_in) begin
        state_n = MARK;
        cnt_n   = ONE_C;
      end else if (cnt >= GAP_LAST_C) begin
        emit    = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
        count_n = 3'd0;
        code_n  = 4'd0;
        ovf_n   = 1'b0;
      end else begin
        cnt_n = cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      count      <= 3'd0;
      code       <= 4'd0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
      char_sel   <= 5'd0;
      char_len   <= 3'd0;
      char_code  <= 4'd0;
      char_err   <= 1'b0;
    end else if (!en) begin
      // Drop the partial character; last emitted results stay visible.
      state      <= IDLE;
      cnt        <= '0;
      count      <= 3'd0;
      code       <= 4'd0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      count      <= count_n;
      code       <= code_n;
      ovf        <= ovf_n;
      char_valid <= emit;
      if (emit) begin
        char_sel  <= dec_sel;
        char_len  <= emit_len;
        char_code <= code;
        char_err  <= (dec_sel == 5'b11111);
      end
    end
  end

  assign state_debug = state;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: directed mark/space patterns push the
// expected character; a negedge monitor pops and compares on char_valid.
module tb_morse_decoder;

  typedef struct {
    logic [4:0] sel;
    logic [2:0] len;
    logic [3:0] code;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       morse_in = 1'b0;
  logic       char_valid;
  logic [4:0] char_sel;
  logic [2:0] char_len;
  logic [3:0] char_code;
  logic       char_err;
  logic [1:0] state_debug;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  morse_decoder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .morse_in(morse_in),
    .char_valid(char_valid), .char_sel(char_sel), .char_len(char_len),
    .char_code(char_code), .char_err(char_err), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (char_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got sel=%0d len=%0d code=%b expected no character",
                 char_sel, char_len, char_code);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sel", int'(char_sel), int'(e.sel));
        chk("len", int'(char_len), int'(e.len));
        chk("code", int'(char_code), int'(e.code));
        chk("err", int'(char_err), int'(e.err));
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic mark(input int n);
    morse_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic space(input int n);
    morse_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_char(input logic [4:0] s, input logic [2:0] l,
                             input logic [3:0] c, input logic e);
    exp_t x;
    x.sel = s; x.len = l; x.code = c; x.err = e;
    sb.push_back(x);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(char_valid), 0);
    chk("rst_sel", int'(char_sel), 0);
    chk("rst_len", int'(char_len), 0);
    chk("rst_code", int'(char_code), 0);
    chk("rst_err", int'(char_err), 0);
    chk("rst_state", int'(state_debug), 0);
    rst_n = 1'b1;
    space(5);

    // A: dot then dash, with an exact-latency probe around the gap
    expect_char(5'd0, 3'd2, 4'b0010, 1'b0);
    mark(100); space(101); mark(200);
    chk("mark_state", int'(state_debug), 1);
    space(299);
    chk("pre_gap_valid", int'(char_valid), 0);
    chk("space_state", int'(state_debug), 2);
    space(1);
    chk("gap_valid", int'(char_valid), 1);
    space(1);
    chk("strobe_one_cycle", int'(char_valid), 0);
    chk("hold_sel", int'(char_sel), 0);
    chk("hold_len", int'(char_len), 2);
    space(20);

    // Z as the keyer would send it: dash dash dot dot
    expect_char(5'd25, 3'd4, 4'b0011, 1'b0);
    mark(180); space(60); mark(180); space(60); mark(60); space(60); mark(60); space(320);

    // Unknown pattern: four dashes
    expect_char(5'b11111, 3'd4, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin mark(200); space(101); end
    space(220);

    // Overflow: five dots
    expect_char(5'b11111, 3'd5, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin mark(100); space(101); end
    space(220);

    // Glitch between two dots
    expect_char(5'd8, 3'd2, 4'b0000, 1'b0);
    mark(100); space(101); mark(10); space(101); mark(100); space(320);

    // Thresholds: 19 rejected, 20 dot, 149 dot, 150 dash -> U
    expect_char(5'd20, 3'd3, 4'b0100, 1'b0);
    mark(19); space(50); mark(20); space(50); mark(149); space(50); mark(150); space(320);

    // Lone glitch in idle never emits
    mark(19); space(320);
    chk("glitch_idle_state", int'(state_debug), 0);

    // Saturated counter still classifies as dash -> T
    expect_char(5'd19, 3'd1, 4'b0001, 1'b0);
    mark(600); space(320);

    // Reset after two dots; then dash -> T
    mark(100); space(101); mark(100); space(50);
    rst_n = 1'b0;
    space(2);
    chk("rst_mid_len", int'(char_len), 0);
    chk("rst_mid_sel", int'(char_sel), 0);
    rst_n = 1'b1;
    space(5);
    expect_char(5'd19, 3'd1, 4'b0001, 1'b0);
    mark(200); space(320);

    // en low after two dots; outputs hold, then dash -> T
    mark(100); space(101); mark(100); space(50);
    en = 1'b0;
    space(2);
    chk("en_state", int'(state_debug), 0);
    chk("en_hold_sel", int'(char_sel), 19);
    chk("en_hold_len", int'(char_len), 1);
    en = 1'b1;
    expect_char(5'd19, 3'd1, 4'b0001, 1'b0);
    mark(200); space(320);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
- Receive-side companion to the Morse keyer. Consumes the serial keyed signal (`out` of MORSE_CODE) and measures mark and space run lengths.
- Classifies each mark as dot or dash, assembles up to 4 elements, and on a character gap emits the letter index in the same 5-bit `sel` encoding the keyer accepts (A=0 … Z=25).
- Gives a loopback checker and the receive path of the Morse subsystem.

Parameters:
- DOT_MIN, 20: minimum mark length in cycles to count as an element; shorter marks are glitches and are discarded.
- DASH_MIN, 150: mark length at or above which the element is a dash; DOT_MIN ≤ length < DASH_MIN is a dot.
- CHAR_GAP, 300: consecutive space cycles that terminate a character.
- CNT_WIDTH, $clog2(CHAR_GAP+1): width of the run-length counter. Must also hold DASH_MIN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decoder enable; low gives a synchronous clear to IDLE.
- morse_in  input  1  keyed signal; 1 = mark, 0 = space. Same clock domain, no synchroniser.
- char_valid  output  1  one-cycle strobe: a character is complete.
- char_sel  output  5  decoded letter index 0–25; 5'b11111 on error.
- char_len  output  3  element count 1–4, or 5 on overflow.
- char_code  output  4  element bits, LSB = first element, dot=0, dash=1, unused bits 0.
- char_err  output  1  qualifies char_valid: unknown pattern or more than 4 elements.
- state_debug  output  2  current FSM state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, element count=0, code=0, overflow=0. All outputs 0 (char_sel=0, char_len=0, char_code=0).
- Output registering: all outputs are registered. char_sel, char_len, char_code and char_err hold their last values until the next char_valid.
- Counter: counts consecutive samples of the current level. Clears to 1 on each level change. Saturates at all-ones and never wraps.
- IDLE state:
  - morse_in=1 → go to MARK, counter=1.
  - morse_in=0 → stay in IDLE.
- MARK state: counter increments while morse_in=1. On the edge that samples the first 0:
  - counter < DOT_MIN: glitch. No element is appended. Go to SPACE if element count > 0, else IDLE. Space counter restarts at 1.
  - DOT_MIN ≤ counter < DASH_MIN: append dot. counter ≥ DASH_MIN: append dash. Includes a saturated counter.
  - Appending writes the bit at position count, then increments count. At count==4, a further element sets the sticky overflow flag; the code is unchanged and count holds at 4.
  - Next state is SPACE, counter=1.
- SPACE state:
  - morse_in=1 → go to MARK, counter=1.
  - Otherwise increment counter. On the edge sampling the CHAR_GAP-th consecutive 0, register the outputs and go to IDLE, clearing count, code and overflow.
- Emit on character gap: char_valid=1 for exactly one cycle, with:
  - char_code = assembled code.
  - char_len = 5 if overflow, else count.
  - char_sel per the keyer table when the lookup is valid.
  - char_err=1 and char_sel=5'b11111 if overflow, or if (len=4 and code ∈ {4'b0111, 4'b1010, 4'b1100, 4'b1111}).
- Decode table (len: code→sel):
  - len 1: 0→E(4), 1→T(19).
  - len 2: 00→I(8), 10→A(0), 01→N(13), 11→M(12).
  - len 3: 000→S(18), 001→D(3), 010→R(17), 011→G(6), 100→U(20), 101→K(10), 110→W(22), 111→O(14).
  - len 4: 0000→H(7), 0001→B(1), 0010→L(11), 0011→Z(25), 0100→F(5), 0101→C(2), 0110→P(15), 1000→V(21), 1001→X(23), 1011→Q(16), 1101→Y(24), 1110→J(9).
- Latency: char_valid is high in the cycle after the edge that samples the CHAR_GAP-th space.
- en=0 (synchronous): same clear as reset, but registered outputs other than char_valid hold. char_valid is forced to 0 and the partial character is dropped.
- Reset mid-character: partial character is discarded and no char_valid is issued.
- A mark that never ends never emits a character. A space in IDLE never emits.

Test Plan:
- Dot-dash timing, marks of 100 and 200 cycles separated by 101-cycle spaces, then 300 low → char_valid once; sel=0 (A), len=2, code=4'b0010, err=0.
- Loopback with the keyer, sel=25 (Z), keyer output wired to morse_in → decoder emits sel=25, len=4, code=4'b0011.
- Unknown pattern, four dashes of 200 cycles, then gap → err=1, sel=5'b11111, len=4, code=4'b1111.
- Overflow, five 100-cycle dots, then gap → err=1, len=5, sel=5'b11111.
- Glitch rejection, a 10-cycle mark between two 100-cycle dots, then gap → sel=8 (I), len=2. Thresholds: 19-cycle mark is rejected, 20 is a dot, 149 is a dot, 150 is a dash.
- Abort, rst_n pulsed low (or en=0) after two dots, then one dash and gap → sel=19 (T), len=1; no earlier char_valid.
